// File: rtl/rvh_l1d_req_dec_arb.sv
// L1D request front end: PTW > store > round-robin loads, opcode decode, one-entry output stage.
// Optional perf counters are enabled by defining RVH_L1D_DEC_PERF_EN.
module rvh_l1d_req_dec_arb #(
   parameter int unsigned N_LD_PORT    = 2,
   parameter int unsigned LDU_OP_WIDTH = 3,
   parameter int unsigned STU_OP_WIDTH = 5,
   parameter int unsigned TAG_W        = 4,
   localparam int unsigned PORT_W      = (N_LD_PORT > 1) ? $clog2(N_LD_PORT) : 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [N_LD_PORT-1:0]            ld_req_vld_i,
   input  logic [N_LD_PORT*LDU_OP_WIDTH-1:0] ld_req_opcode_i,
   input  logic [N_LD_PORT*TAG_W-1:0]      ld_req_tag_i,
   output logic [N_LD_PORT-1:0]            ld_req_rdy_o,
   input  logic                            st_req_vld_i,
   input  logic [STU_OP_WIDTH-1:0]         st_req_opcode_i,
   input  logic [TAG_W-1:0]                st_req_tag_i,
   output logic                            st_req_rdy_o,
   input  logic                            ptw_req_vld_i,
   input  logic [TAG_W-1:0]                ptw_req_tag_i,
   output logic                            ptw_req_rdy_o,
   output logic                            dec_vld_o,
   input  logic                            dec_rdy_i,
   output logic [14:0]                     dec_req_type_o,
   output logic [1:0]                      dec_src_o,
   output logic [PORT_W-1:0]               dec_ld_port_o,
   output logic [TAG_W-1:0]                dec_tag_o,
   output logic                            dec_illegal_o
`ifdef RVH_L1D_DEC_PERF_EN
  ,output logic [31:0]                     perf_ld_cnt_o,
   output logic [31:0]                     perf_st_cnt_o,
   output logic [31:0]                     perf_ptw_cnt_o,
   output logic [31:0]                     perf_stall_cnt_o
`endif
);

   logic [PORT_W-1:0]       rr_q;
   logic [PORT_W-1:0]       ld_win;
   logic                    ld_any;
   logic                    gnt_ptw, gnt_st, gnt_ld;
   logic                    can_acc, acc;
   logic [LDU_OP_WIDTH-1:0] ld_op;
   logic [TAG_W-1:0]        ld_tag;
   int unsigned             lop, sop;

   logic                    vld_q;
   logic [14:0]             type_q, type_d;
   logic [1:0]              src_q, src_d;
   logic [PORT_W-1:0]       port_q, port_d;
   logic [TAG_W-1:0]        tag_q, tag_d;
   logic                    ill_q, ill_d;
   logic [2:0]              amo_func;

   // Two passes: ports at or above rr_q first, then wrap to the lower ones.
   always_comb begin
      ld_any = 1'b0;
      ld_win = '0;
      for (int i = 0; i < N_LD_PORT; i++) begin
         if (!ld_any && ld_req_vld_i[i] && (PORT_W'(i) >= rr_q)) begin
            ld_any = 1'b1;
            ld_win = PORT_W'(i);
         end
      end
      for (int i = 0; i < N_LD_PORT; i++) begin
         if (!ld_any && ld_req_vld_i[i]) begin
            ld_any = 1'b1;
            ld_win = PORT_W'(i);
         end
      end
   end

   always_comb begin
      ld_op  = '0;
      ld_tag = '0;
      for (int i = 0; i < N_LD_PORT; i++) begin
         if (ld_win == PORT_W'(i)) begin
            ld_op  = ld_req_opcode_i[i*LDU_OP_WIDTH +: LDU_OP_WIDTH];
            ld_tag = ld_req_tag_i[i*TAG_W +: TAG_W];
         end
      end
   end

   assign gnt_ptw = ptw_req_vld_i;
   assign gnt_st  = st_req_vld_i & ~ptw_req_vld_i;
   assign gnt_ld  = ld_any & ~st_req_vld_i & ~ptw_req_vld_i;
   assign can_acc = ~vld_q | dec_rdy_i;
   assign acc     = (gnt_ptw | gnt_st | gnt_ld) & can_acc;

   assign ptw_req_rdy_o = gnt_ptw & can_acc;
   assign st_req_rdy_o  = gnt_st & can_acc;

   always_comb begin
      ld_req_rdy_o = '0;
      for (int i = 0; i < N_LD_PORT; i++) begin
         ld_req_rdy_o[i] = gnt_ld & can_acc & (ld_win == PORT_W'(i));
      end
   end

   assign lop = 32'(ld_op);
   assign sop = 32'(st_req_opcode_i);

   always_comb begin
      case (sop)
         11, 12:         amo_func = 3'd0;
         13, 14:         amo_func = 3'd1;
         15, 16:         amo_func = 3'd2;
         17, 18:         amo_func = 3'd3;
         19, 20:         amo_func = 3'd4;
         21, 22, 23, 24: amo_func = 3'd5;
         default:        amo_func = 3'd6;
      endcase
   end

   always_comb begin
      type_d = '0;
      ill_d  = 1'b0;
      src_d  = 2'd0;
      port_d = '0;
      tag_d  = ld_tag;
      if (gnt_ptw) begin
         src_d  = 2'd2;
         tag_d  = ptw_req_tag_i;
         type_d = 15'h2002;
      end else if (gnt_st) begin
         src_d = 2'd1;
         tag_d = st_req_tag_i;
         case (sop)
            0:       type_d = 15'h1010;
            1:       type_d = 15'h1008;
            2:       type_d = 15'h1004;
            3:       type_d = 15'h1002;
            7:       type_d = 15'h0044;
            8:       type_d = 15'h0042;
            9:       type_d = 15'h0024;
            10:      type_d = 15'h0022;
            default: begin
               if (sop >= 11 && sop <= 28) begin
                  type_d[11]  = 1'b1;
                  type_d[10]  = (sop == 23) || (sop == 24) || (sop == 27) || (sop == 28);
                  type_d[9:7] = amo_func;
                  type_d[2]   = st_req_opcode_i[0];
                  type_d[1]   = ~st_req_opcode_i[0];
               end else begin
                  ill_d = 1'b1;
               end
            end
         endcase
      end else begin
         port_d = ld_win;
         case (lop)
            0:       type_d = 15'h4010;
            1:       type_d = 15'h4008;
            2:       type_d = 15'h4004;
            3:       type_d = 15'h4011;
            4:       type_d = 15'h4009;
            5:       type_d = 15'h4005;
            6:       type_d = 15'h4002;
            default: ill_d  = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         type_q <= '0;
         src_q  <= '0;
         port_q <= '0;
         tag_q  <= '0;
         ill_q  <= 1'b0;
         rr_q   <= '0;
      end else begin
         if (acc) begin
            vld_q  <= 1'b1;
            type_q <= type_d;
            src_q  <= src_d;
            port_q <= port_d;
            tag_q  <= tag_d;
            ill_q  <= ill_d;
            if (gnt_ld) begin
               rr_q <= (ld_win == PORT_W'(N_LD_PORT - 1)) ? '0 : ld_win + 1'b1;
            end
         end else if (can_acc) begin
            vld_q <= 1'b0;
         end
      end
   end

   assign dec_vld_o      = vld_q;
   assign dec_req_type_o = type_q;
   assign dec_src_o      = src_q;
   assign dec_ld_port_o  = port_q;
   assign dec_tag_o      = tag_q;
   assign dec_illegal_o  = ill_q;

`ifdef RVH_L1D_DEC_PERF_EN
   logic [31:0] ld_cnt_q, st_cnt_q, ptw_cnt_q, stall_cnt_q;
   logic        any_vld;

   assign any_vld = ptw_req_vld_i | st_req_vld_i | (|ld_req_vld_i);

   // Saturating counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_cnt_q    <= '0;
         st_cnt_q    <= '0;
         ptw_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (acc && gnt_ld && ld_cnt_q != '1)        ld_cnt_q    <= ld_cnt_q + 32'd1;
         if (acc && gnt_st && st_cnt_q != '1)        st_cnt_q    <= st_cnt_q + 32'd1;
         if (acc && gnt_ptw && ptw_cnt_q != '1)      ptw_cnt_q   <= ptw_cnt_q + 32'd1;
         if (any_vld && !acc && stall_cnt_q != '1)   stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign perf_ld_cnt_o    = ld_cnt_q;
   assign perf_st_cnt_o    = st_cnt_q;
   assign perf_ptw_cnt_o   = ptw_cnt_q;
   assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rvh_l1d_req_dec_arb.sv
// Bench for rvh_l1d_req_dec_arb: directed literal checks plus randomized traffic against a
// transaction-level model of the arbiter, decoder and output stage.
module tb_rvh_l1d_req_dec_arb;
   localparam int N  = 2;
   localparam int LW = 3;
   localparam int SW = 5;
   localparam int TW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    ld_req_vld_i;
   logic [N*LW-1:0] ld_req_opcode_i;
   logic [N*TW-1:0] ld_req_tag_i;
   logic [N-1:0]    ld_req_rdy_o;
   logic            st_req_vld_i;
   logic [SW-1:0]   st_req_opcode_i;
   logic [TW-1:0]   st_req_tag_i;
   logic            st_req_rdy_o;
   logic            ptw_req_vld_i;
   logic [TW-1:0]   ptw_req_tag_i;
   logic            ptw_req_rdy_o;
   logic            dec_vld_o;
   logic            dec_rdy_i;
   logic [14:0]     dec_req_type_o;
   logic [1:0]      dec_src_o;
   logic [0:0]      dec_ld_port_o;
   logic [TW-1:0]   dec_tag_o;
   logic            dec_illegal_o;
`ifdef RVH_L1D_DEC_PERF_EN
   logic [31:0]     perf_ld, perf_st, perf_ptw, perf_stall;
`endif

   rvh_l1d_req_dec_arb #(
      .N_LD_PORT(N), .LDU_OP_WIDTH(LW), .STU_OP_WIDTH(SW), .TAG_W(TW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_req_vld_i(ld_req_vld_i), .ld_req_opcode_i(ld_req_opcode_i),
      .ld_req_tag_i(ld_req_tag_i), .ld_req_rdy_o(ld_req_rdy_o),
      .st_req_vld_i(st_req_vld_i), .st_req_opcode_i(st_req_opcode_i),
      .st_req_tag_i(st_req_tag_i), .st_req_rdy_o(st_req_rdy_o),
      .ptw_req_vld_i(ptw_req_vld_i), .ptw_req_tag_i(ptw_req_tag_i),
      .ptw_req_rdy_o(ptw_req_rdy_o),
      .dec_vld_o(dec_vld_o), .dec_rdy_i(dec_rdy_i), .dec_req_type_o(dec_req_type_o),
      .dec_src_o(dec_src_o), .dec_ld_port_o(dec_ld_port_o), .dec_tag_o(dec_tag_o),
      .dec_illegal_o(dec_illegal_o)
`ifdef RVH_L1D_DEC_PERF_EN
     ,.perf_ld_cnt_o(perf_ld), .perf_st_cnt_o(perf_st), .perf_ptw_cnt_o(perf_ptw),
      .perf_stall_cnt_o(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model of the held request and round-robin start point.
   bit          m_vld;
   logic [14:0] m_type;
   int          m_src, m_port, m_rr;
   logic [3:0]  m_tag;
   bit          m_ill;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Returns {illegal, type} from the opcode tables; src 0 load, 1 store, 2 ptw.
   function automatic logic [15:0] ref_dec(input int src, input int op);
      logic [14:0] t = '0;
      bit          ill = 0;
      int          sz, func;
      if (src == 2) begin
         t[13] = 1; t[1] = 1;
      end else if (src == 0) begin
         if (op > 6) ill = 1;
         else begin
            t[14] = 1;
            if (op == 6) t[1] = 1;
            else begin
               sz = op % 3;
               t[4 - sz] = 1;
               if (op >= 3) t[0] = 1;
            end
         end
      end else begin
         if (op <= 3) begin
            t[12] = 1; t[4 - op] = 1;
         end else if (op >= 7 && op <= 28) begin
            if (op % 2 == 0) t[1] = 1; else t[2] = 1;
            if (op <= 8) t[6] = 1;
            else if (op <= 10) t[5] = 1;
            else begin
               t[11] = 1;
               t[10] = (op == 23 || op == 24 || op == 27 || op == 28);
               func  = (op <= 20) ? (op - 11) / 2 : ((op <= 24) ? 5 : 6);
               t[9:7] = 3'(func);
            end
         end else ill = 1;
      end
      return {ill, t};
   endfunction

   task automatic model_reset();
      m_vld = 0; m_type = '0; m_src = 0; m_port = 0; m_tag = '0; m_ill = 0; m_rr = 0;
   endtask

   // Compare this cycle's DUT outputs with the model, then advance the model across the edge.
   task automatic settle();
      int          win, port;
      bit          can;
      logic [N-1:0] exp_ld;
      logic [15:0] d;
      #1;
      can  = !m_vld || dec_rdy_i;
      win  = -1;
      port = 0;
      if (ptw_req_vld_i) win = 2;
      else if (st_req_vld_i) win = 1;
      else begin
         for (int k = 0; k < N; k++) begin
            int p = (m_rr + k) % N;
            if (win < 0 && ld_req_vld_i[p]) begin
               win = 0; port = p;
            end
         end
      end
      exp_ld = '0;
      if (win == 0 && can) exp_ld[port] = 1'b1;
      chk("ptw_rdy", 32'(ptw_req_rdy_o), 32'(win == 2 && can));
      chk("st_rdy",  32'(st_req_rdy_o),  32'(win == 1 && can));
      chk("ld_rdy",  32'(ld_req_rdy_o),  32'(exp_ld));
      chk("vld",     32'(dec_vld_o),     32'(m_vld));
      if (m_vld) begin
         chk("type", 32'(dec_req_type_o), 32'(m_type));
         chk("src",  32'(dec_src_o),      32'(m_src));
         chk("port", 32'(dec_ld_port_o),  32'(m_port));
         chk("tag",  32'(dec_tag_o),      32'(m_tag));
         chk("ill",  32'(dec_illegal_o),  32'(m_ill));
      end
      if (win >= 0 && can) begin
         m_vld = 1;
         m_src = win;
         m_port = (win == 0) ? port : 0;
         if (win == 2) begin
            d = ref_dec(2, 0); m_tag = ptw_req_tag_i;
         end else if (win == 1) begin
            d = ref_dec(1, int'(st_req_opcode_i)); m_tag = st_req_tag_i;
         end else begin
            d = ref_dec(0, int'(ld_req_opcode_i[port*LW +: LW]));
            m_tag = ld_req_tag_i[port*TW +: TW];
            m_rr = (port + 1) % N;
         end
         m_ill = d[15];
         m_type = d[14:0];
      end else if (can) begin
         m_vld = 0;
      end
   endtask

   task automatic adv();
      @(negedge clk);
   endtask

   task automatic idle();
      ld_req_vld_i = '0; ld_req_opcode_i = '0; ld_req_tag_i = '0;
      st_req_vld_i = 0; st_req_opcode_i = '0; st_req_tag_i = '0;
      ptw_req_vld_i = 0; ptw_req_tag_i = '0;
   endtask

   task automatic set_ld(input int p, input int op, input int tag);
      ld_req_vld_i[p] = 1'b1;
      ld_req_opcode_i[p*LW +: LW] = LW'(op);
      ld_req_tag_i[p*TW +: TW] = TW'(tag);
   endtask

   initial begin
      rst_n = 0; dec_rdy_i = 1; idle(); model_reset();
      adv(); adv();
      rst_n = 1;
      chk("rst_vld",  32'(dec_vld_o), 0);
      chk("rst_type", 32'(dec_req_type_o), 0);
      chk("rst_src",  32'(dec_src_o), 0);
      chk("rst_port", 32'(dec_ld_port_o), 0);
      chk("rst_tag",  32'(dec_tag_o), 0);
      chk("rst_ill",  32'(dec_illegal_o), 0);

      // PTW beats store beats load.
      ptw_req_vld_i = 1; ptw_req_tag_i = 4'h6;
      st_req_vld_i = 1; st_req_opcode_i = 5'd3;
      set_ld(0, 0, 1);
      settle();
      chk("prio_ptw_rdy", 32'(ptw_req_rdy_o), 1);
      chk("prio_st_rdy",  32'(st_req_rdy_o), 0);
      chk("prio_ld_rdy",  32'(ld_req_rdy_o), 0);
      adv(); idle(); settle();
      chk("prio_src",  32'(dec_src_o), 2);
      chk("prio_type", 32'(dec_req_type_o), 32'h2002);
      adv();

      // Round-robin alternation.
      for (int k = 0; k < 4; k++) begin
         set_ld(0, 2, k); set_ld(1, 5, k + 8);
         settle();
         chk("rr_grant", 32'(ld_req_rdy_o), (k % 2 == 0) ? 32'h1 : 32'h2);
         if (k > 0) chk("rr_vld", 32'(dec_vld_o), 1);
         adv();
      end
      idle();

      // AMO word, func 5.
      st_req_vld_i = 1; st_req_opcode_i = 5'd21; st_req_tag_i = 4'd5;
      settle(); adv(); idle(); settle();
      chk("amo_type", 32'(dec_req_type_o), 32'h0A84);
      chk("amo_tag",  32'(dec_tag_o), 5);
      adv();

      // Back-pressure while full.
      set_ld(0, 1, 3);
      settle(); adv();
      idle(); set_ld(1, 4, 9); dec_rdy_i = 0;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("stall_rdy", 32'({ld_req_rdy_o, st_req_rdy_o, ptw_req_rdy_o}), 0);
         chk("stall_tag", 32'(dec_tag_o), 3);
         adv();
      end
      dec_rdy_i = 1;
      settle();
      chk("drain_rdy", 32'(ld_req_rdy_o), 32'h2);
      adv(); idle(); settle();
      chk("drain_tag", 32'(dec_tag_o), 9);
      adv();

      // Illegal opcodes.
      set_ld(0, 7, 2); settle(); adv(); idle(); settle();
      chk("ill_ld_flag", 32'(dec_illegal_o), 1);
      chk("ill_ld_type", 32'(dec_req_type_o), 0);
      adv();
      st_req_vld_i = 1; st_req_opcode_i = 5'd30; settle(); adv(); idle(); settle();
      chk("ill_st_flag", 32'(dec_illegal_o), 1);
      chk("ill_st_type", 32'(dec_req_type_o), 0);
      adv();

      // Reset while full restores rr_ptr to 0.
      set_ld(1, 0, 1); settle(); adv();
      idle(); set_ld(0, 0, 1); settle(); adv();
      idle(); dec_rdy_i = 0;
      #2 rst_n = 0; model_reset();
      #1 chk("rst_mid_vld", 32'(dec_vld_o), 0);
      adv();
      rst_n = 1; dec_rdy_i = 1;
      set_ld(0, 6, 4); set_ld(1, 6, 5);
      settle();
      chk("rst_rr", 32'(ld_req_rdy_o), 32'h1);
      adv();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         ptw_req_vld_i   = ($urandom % 6) == 0;
         ptw_req_tag_i   = TW'($urandom);
         st_req_vld_i    = ($urandom % 4) == 0;
         st_req_opcode_i = SW'($urandom);
         st_req_tag_i    = TW'($urandom);
         ld_req_vld_i    = N'($urandom);
         ld_req_opcode_i = (N*LW)'($urandom);
         ld_req_tag_i    = (N*TW)'($urandom);
         dec_rdy_i       = ($urandom % 4) != 0;
         settle();
         adv();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
